// File: rtl/zap_fetch_buffer.sv
// Prefetch FIFO between the I-cache and decode, with the bimodal branch predictor table.
// Define ZAP_FETCH_BP_EN to build the predictor table; otherwise every entry is predicted WNT.
module zap_fetch_buffer #(
    parameter int DEPTH      = 4,
    parameter int BP_ENTRIES = 1024
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_clear_from_writeback,
    input  logic        i_data_stall,
    input  logic        i_clear_from_alu,
    input  logic        i_stall_from_shifter,
    input  logic        i_stall_from_issue,
    input  logic        i_stall_from_decode,
    input  logic        i_clear_from_decode,
    input  logic [31:0] i_pc_ff,
    input  logic        i_cpsr_ff_t,
    input  logic [31:0] i_instruction,
    input  logic        i_valid,
    input  logic        i_instr_abort,
    output logic        o_icache_stall,
    output logic [31:0] o_instruction,
    output logic        o_valid,
    output logic        o_instr_abort,
    output logic [31:0] o_pc_ff,
    output logic [31:0] o_pc_plus_8_ff,
    output logic [1:0]  o_taken_ff,
    input  logic        i_confirm_from_alu,
    input  logic [31:0] i_pc_from_alu,
    input  logic [1:0]  i_taken
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int BW = $clog2(BP_ENTRIES);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [1:0] WNT = 2'd1;

    logic [31:0]   mem_instr [DEPTH];
    logic          mem_abort [DEPTH];
    logic [31:0]   mem_pc    [DEPTH];
    logic [31:0]   mem_pc8   [DEPTH];
    logic [1:0]    mem_taken [DEPTH];

    logic [PW-1:0] rd_ptr, wr_ptr, rd_next;
    logic [CW-1:0] count, count_next, remain;
    logic          sleep;
    logic          any_stall, flush, pop, push, bypass;
    logic [31:0]   push_pc8;
    logic [1:0]    lookup_taken;

    assign any_stall = i_data_stall | i_stall_from_shifter | i_stall_from_issue | i_stall_from_decode;
    assign flush     = i_clear_from_writeback | (!i_data_stall & i_clear_from_alu) |
                       (!any_stall & i_clear_from_decode);
    assign pop       = o_valid & !any_stall & !flush;
    assign push      = i_valid & !sleep & !flush & ((count != FULL) | pop);
    assign o_icache_stall = (count == FULL) & !pop;
    assign push_pc8  = i_cpsr_ff_t ? i_pc_ff + 32'd4 : i_pc_ff + 32'd8;

    // When no older entry survives this cycle, the new head is the word being pushed.
    assign remain = count - CW'(pop);
    assign bypass = (remain == '0);
    assign rd_next = pop ? rd_ptr + PW'(1) : rd_ptr;

    always_comb begin
        count_next = count;
        if (flush)
            count_next = '0;
        else if (push && !pop)
            count_next = count + CW'(1);
        else if (pop && !push)
            count_next = count - CW'(1);
    end

`ifdef ZAP_FETCH_BP_EN
    logic [1:0]    bp_table [BP_ENTRIES];
    logic [BW-1:0] alu_idx;
    logic [1:0]    bp_cur, bp_next;
    logic          bp_we;
    logic          unused_bits;

    assign alu_idx      = i_pc_from_alu[BW:1];
    assign bp_cur       = bp_table[alu_idx];
    assign bp_we        = !i_data_stall & (i_clear_from_alu | i_confirm_from_alu);
    assign lookup_taken = bp_table[i_pc_ff[BW:1]];
    assign unused_bits  = ^{i_taken, i_pc_from_alu[31:BW+1], i_pc_from_alu[0]};

    // Mispredict moves a strong state to its weak twin and flips weak states; confirm saturates.
    always_comb begin
        bp_next = bp_cur;
        if (i_clear_from_alu)
            bp_next = (bp_cur == 2'd0 || bp_cur == 2'd2) ? 2'd1 : 2'd2;
        else if (i_confirm_from_alu)
            bp_next = bp_cur[1] ? 2'd3 : 2'd0;
    end

    always_ff @(posedge i_clk) begin
        if (bp_we)
            bp_table[alu_idx] <= bp_next;
    end
`else
    logic unused_bits;

    assign lookup_taken = WNT;
    assign unused_bits  = ^{i_taken, i_pc_from_alu, i_confirm_from_alu};
`endif

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_instr[wr_ptr] <= i_instruction;
            mem_abort[wr_ptr] <= i_instr_abort;
            mem_pc[wr_ptr]    <= i_pc_ff;
            mem_pc8[wr_ptr]   <= push_pc8;
            mem_taken[wr_ptr] <= lookup_taken;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            count          <= '0;
            sleep          <= 1'b0;
            o_valid        <= 1'b0;
            o_instr_abort  <= 1'b0;
            o_instruction  <= 32'd0;
            o_pc_ff        <= 32'd0;
            o_pc_plus_8_ff <= 32'd8;
            o_taken_ff     <= WNT;
        end else begin
            count <= count_next;
            if (flush) begin
                rd_ptr        <= '0;
                wr_ptr        <= '0;
                sleep         <= 1'b0;
                o_valid       <= 1'b0;
                o_instr_abort <= 1'b0;
            end else begin
                rd_ptr  <= rd_next;
                o_valid <= (count_next != '0);
                if (push) begin
                    wr_ptr <= wr_ptr + PW'(1);
                    if (i_instr_abort)
                        sleep <= 1'b1;
                end
                if (count_next != '0) begin
                    o_instruction  <= bypass ? i_instruction : mem_instr[rd_next];
                    o_instr_abort  <= bypass ? i_instr_abort : mem_abort[rd_next];
                    o_pc_ff        <= bypass ? i_pc_ff       : mem_pc[rd_next];
                    o_pc_plus_8_ff <= bypass ? push_pc8      : mem_pc8[rd_next];
                    o_taken_ff     <= bypass ? lookup_taken  : mem_taken[rd_next];
                end
            end
        end
    end

endmodule

// File: tb/tb_zap_fetch_buffer.sv
// Randomized bench for zap_fetch_buffer against a queue-based reference model.
// Compile with ZAP_FETCH_BP_EN defined to also check the predictor table.
module tb_zap_fetch_buffer;

    localparam int DEPTH      = 4;
    localparam int BP_ENTRIES = 1024;
    localparam int CYCLES     = 3000;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_clear_from_writeback, i_data_stall, i_clear_from_alu;
    logic        i_stall_from_shifter, i_stall_from_issue, i_stall_from_decode;
    logic        i_clear_from_decode;
    logic [31:0] i_pc_ff;
    logic        i_cpsr_ff_t;
    logic [31:0] i_instruction;
    logic        i_valid, i_instr_abort;
    logic        o_icache_stall;
    logic [31:0] o_instruction;
    logic        o_valid, o_instr_abort;
    logic [31:0] o_pc_ff, o_pc_plus_8_ff;
    logic [1:0]  o_taken_ff;
    logic        i_confirm_from_alu;
    logic [31:0] i_pc_from_alu;
    logic [1:0]  i_taken;

    always #5 i_clk = ~i_clk;

    zap_fetch_buffer #(.DEPTH(DEPTH), .BP_ENTRIES(BP_ENTRIES)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_clear_from_writeback(i_clear_from_writeback), .i_data_stall(i_data_stall),
        .i_clear_from_alu(i_clear_from_alu), .i_stall_from_shifter(i_stall_from_shifter),
        .i_stall_from_issue(i_stall_from_issue), .i_stall_from_decode(i_stall_from_decode),
        .i_clear_from_decode(i_clear_from_decode), .i_pc_ff(i_pc_ff),
        .i_cpsr_ff_t(i_cpsr_ff_t), .i_instruction(i_instruction), .i_valid(i_valid),
        .i_instr_abort(i_instr_abort), .o_icache_stall(o_icache_stall),
        .o_instruction(o_instruction), .o_valid(o_valid), .o_instr_abort(o_instr_abort),
        .o_pc_ff(o_pc_ff), .o_pc_plus_8_ff(o_pc_plus_8_ff), .o_taken_ff(o_taken_ff),
        .i_confirm_from_alu(i_confirm_from_alu), .i_pc_from_alu(i_pc_from_alu),
        .i_taken(i_taken)
    );

    typedef struct {
        logic [31:0] instr;
        logic        abort;
        logic [31:0] pc;
        logic [31:0] pc8;
        logic [1:0]  a;
        int          idx;
        bit          fixed;
    } entry_t;

    entry_t q[$];
    entry_t held;
    bit     sleep_m;
    int     checks = 0;
    int     errors = 0;

    // Predictor contents are never reset, so the model assumes zero and learns whether the
    // real entry is the mirror image (3-v); clear/confirm commute with that mirroring.
    logic [1:0] tbl [BP_ENTRIES];
    bit         mirror_known [BP_ENTRIES];
    bit         mirror [BP_ENTRIES];

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [1:0] after_clear(input logic [1:0] s);
        case (s)
            2'd0:    return 2'd1;
            2'd1:    return 2'd2;
            2'd2:    return 2'd1;
            default: return 2'd2;
        endcase
    endfunction

    function automatic logic [1:0] after_confirm(input logic [1:0] s);
        return (s >= 2'd2) ? 2'd3 : 2'd0;
    endfunction

    task automatic model_reset();
        q.delete();
        sleep_m = 1'b0;
        held = '{instr: 32'd0, abort: 1'b0, pc: 32'd0, pc8: 32'd8, a: 2'd1, idx: 0, fixed: 1'b1};
    endtask

    task automatic applyStimulus(input int cyc);
        bit heavy;
        heavy = ((cyc / 64) % 2) == 1;
        i_reset = (cyc % 1000) == 500;
        if (i_reset)
            model_reset();
        i_valid                = $urandom_range(0, 9) < 7;
        i_instr_abort          = $urandom_range(0, 99) < 3;
        i_cpsr_ff_t            = $urandom_range(0, 1) == 1;
        i_pc_ff                = 32'($urandom_range(0, 31)) * 32'd4;
        i_instruction          = $urandom;
        i_data_stall           = $urandom_range(0, 99) < 15;
        i_stall_from_shifter   = $urandom_range(0, 99) < 10;
        i_stall_from_issue     = $urandom_range(0, 99) < 10;
        i_stall_from_decode    = $urandom_range(0, 99) < (heavy ? 80 : 10);
        i_clear_from_writeback = $urandom_range(0, 99) < 2;
        i_clear_from_alu       = $urandom_range(0, 99) < 5;
        i_clear_from_decode    = $urandom_range(0, 99) < 4;
        i_confirm_from_alu     = $urandom_range(0, 99) < 15;
        i_pc_from_alu          = 32'($urandom_range(0, 31)) * 32'd4;
        i_taken                = 2'($urandom_range(0, 3));
    endtask

    task automatic checkTaken();
`ifdef ZAP_FETCH_BP_EN
        if (held.fixed)
            checkOutput("taken", 32'(o_taken_ff), 32'(held.a));
        else if (mirror_known[held.idx])
            checkOutput("taken", 32'(o_taken_ff),
                        32'(mirror[held.idx] ? 2'd3 - held.a : held.a));
        else begin
            checkOutput("taken_pair",
                        32'((o_taken_ff == held.a) || (o_taken_ff == 2'd3 - held.a)), 32'd1);
            mirror_known[held.idx] = 1'b1;
            mirror[held.idx]       = (o_taken_ff != held.a);
        end
`else
        checkOutput("taken", 32'(o_taken_ff), 32'd1);
`endif
    endtask

    function automatic bit model_pop();
        bit any_stall, flush;
        any_stall = i_data_stall | i_stall_from_shifter | i_stall_from_issue | i_stall_from_decode;
        flush = i_clear_from_writeback | (!i_data_stall & i_clear_from_alu) |
                (!any_stall & i_clear_from_decode);
        return (q.size() != 0) && !any_stall && !flush;
    endfunction

    task automatic model_step();
        bit any_stall, flush, pop, push;
        entry_t e;
        int aidx;
        any_stall = i_data_stall | i_stall_from_shifter | i_stall_from_issue | i_stall_from_decode;
        flush = i_clear_from_writeback | (!i_data_stall & i_clear_from_alu) |
                (!any_stall & i_clear_from_decode);
        pop  = model_pop();
        push = i_valid && !sleep_m && !flush && ((q.size() < DEPTH) || pop);

        e.instr = i_instruction;
        e.abort = i_instr_abort;
        e.pc    = i_pc_ff;
        e.pc8   = i_cpsr_ff_t ? i_pc_ff + 32'd4 : i_pc_ff + 32'd8;
        e.idx   = int'((i_pc_ff >> 1) % BP_ENTRIES);
`ifdef ZAP_FETCH_BP_EN
        e.a     = tbl[e.idx];
        e.fixed = 1'b0;
`else
        e.a     = 2'd1;
        e.fixed = 1'b1;
`endif

        if (flush) begin
            q.delete();
            sleep_m   = 1'b0;
            held.abort = 1'b0;
        end else begin
            if (pop)
                void'(q.pop_front());
            if (push) begin
                q.push_back(e);
                if (e.abort)
                    sleep_m = 1'b1;
            end
            if (q.size() != 0)
                held = q[0];
        end

        if (!i_data_stall && (i_clear_from_alu || i_confirm_from_alu)) begin
            aidx = int'((i_pc_from_alu >> 1) % BP_ENTRIES);
            tbl[aidx] = i_clear_from_alu ? after_clear(tbl[aidx]) : after_confirm(tbl[aidx]);
        end
    endtask

    initial begin
        for (int i = 0; i < BP_ENTRIES; i++) begin
            tbl[i]          = 2'd0;
            mirror_known[i] = 1'b0;
            mirror[i]       = 1'b0;
        end
        model_reset();
        i_reset = 1'b1;
        i_clear_from_writeback = 0; i_data_stall = 0; i_clear_from_alu = 0;
        i_stall_from_shifter = 0; i_stall_from_issue = 0; i_stall_from_decode = 0;
        i_clear_from_decode = 0; i_pc_ff = 0; i_cpsr_ff_t = 0; i_instruction = 0;
        i_valid = 0; i_instr_abort = 0; i_confirm_from_alu = 0; i_pc_from_alu = 0; i_taken = 0;
        repeat (2) @(negedge i_clk);
        i_reset = 1'b0;

        for (int cyc = 0; cyc < CYCLES; cyc++) begin
            @(negedge i_clk);
            applyStimulus(cyc);
            #1;
            checkOutput("valid", 32'(o_valid), 32'(q.size() != 0));
            checkOutput("instr", o_instruction, held.instr);
            checkOutput("abort", 32'(o_instr_abort), 32'(held.abort));
            checkOutput("pc", o_pc_ff, held.pc);
            checkOutput("pc_plus_8", o_pc_plus_8_ff, held.pc8);
            checkTaken();
            checkOutput("icache_stall", 32'(o_icache_stall),
                        32'((q.size() == DEPTH) && !model_pop()));
            if (!i_reset)
                model_step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/zap_fetch_buffer.md
Name: zap_fetch_buffer

Overview:
Parametrised fetch-stage successor. Decouples the I-cache from decode with a DEPTH-entry prefetch FIFO carrying instruction, abort flag, PC, PC+8/+4 and a 2-bit branch prediction. Backpressures the I-cache when full, sleeps after an instruction abort, and owns the bimodal predictor table. Sits between the I-cache and zap_decode_main.

Parameters:
DEPTH, 4, FIFO entries; power of two, >= 2.
BP_ENTRIES, 1024, predictor counters; power of two, >= 4.

Ports:
i_clk  in  1  ZAP clock.
i_reset  in  1  Asynchronous, active-high reset.
i_clear_from_writeback  in  1  Flush, highest priority.
i_data_stall  in  1  Freeze pop side and predictor writes.
i_clear_from_alu  in  1  Flush; also predictor mispredict update.
i_stall_from_shifter  in  1  Freeze pop side.
i_stall_from_issue  in  1  Freeze pop side.
i_stall_from_decode  in  1  Freeze pop side.
i_clear_from_decode  in  1  Flush, lowest priority.
i_pc_ff  in  32  PC of instruction presented by I-cache.
i_cpsr_ff_t  in  1  CPSR T bit.
i_instruction  in  32  I-cache instruction.
i_valid  in  1  I-cache data valid.
i_instr_abort  in  1  Instruction abort (arrives with i_valid=1).
o_icache_stall  out  1  Buffer cannot accept; I-cache must hold.
o_instruction  out  32  Head instruction.
o_valid  out  1  Head valid.
o_instr_abort  out  1  Head abort flag.
o_pc_ff  out  32  Head PC.
o_pc_plus_8_ff  out  32  Head PC+8 (ARM) / PC+4 (T).
o_taken_ff  out  2  Head prediction.
i_confirm_from_alu  in  1  Predictor confirm update.
i_pc_from_alu  in  32  PC of resolved branch.
i_taken  in  2  Prediction that travelled with resolved branch.

Behaviour:
- Reset (async): FIFO empty, count=0, sleep=0; o_valid=0, o_instr_abort=0, o_instruction=0, o_pc_ff=0, o_pc_plus_8_ff=8, o_taken_ff=WNT(1), o_icache_stall=0. Predictor contents not reset.
- Outputs are registered head-of-FIFO fields; when empty o_valid=0, other fields hold last value.
- Flush = i_clear_from_writeback | (!i_data_stall & i_clear_from_alu) | (!any_stall & i_clear_from_decode), any_stall = data|shifter|issue|decode stall. Flush: count=0, o_valid=0, o_instr_abort=0, sleep=0, push in same cycle discarded.
- Pop: o_valid & !any_stall & !flush; next entry visible next cycle.
- Push: i_valid & !sleep & !flush & (count<DEPTH | pop). Stalls do not block push. Entry = {i_instruction, i_instr_abort, i_pc_ff, i_cpsr_ff_t ? i_pc_ff+4 : i_pc_ff+8, pred[i_pc_ff[log2(BP_ENTRIES):1]]}.
- Latency push->o_valid: 1 cycle when empty (no combinational bypass).
- o_icache_stall = (count==DEPTH) & !pop; combinational.
- Abort push sets sleep=1; while sleep, no pushes; entries already queued still drain; only a flush clears sleep.
- Pointers wrap modulo DEPTH; count in [0,DEPTH]; simultaneous push+pop keeps count.
- Predictor: write when !i_data_stall & (i_clear_from_alu | i_confirm_from_alu), index i_pc_from_alu[log2(BP_ENTRIES):1]. Clear: SNT->WNT, WNT->WT, WT->WNT, ST->WT. Confirm: SNT,WNT->SNT; WT,ST->ST. Clear wins if both. Same-cycle write and lookup to same index: lookup returns old value.

Optional Feature:
ZAP_FETCH_BP_EN: defined -> predictor table as above. Undefined -> no table, every entry's taken field = WNT(1), update inputs ignored.

Test Plan:
- Reset mid-stream with 3 entries queued -> next cycle o_valid=0, o_pc_plus_8_ff=8, o_icache_stall=0.
- Push 4 (DEPTH=4) with i_stall_from_decode=1 -> o_icache_stall=1; 5th held; release stall -> pops PCs 0,4,8,12 in order, 16 accepted.
- T=1, i_pc_ff=0x100 -> o_pc_plus_8_ff=0x104; T=0 -> 0x108.
- Abort at PC 0x20 followed by i_valid pushes -> one o_instr_abort=1 entry, nothing after; i_clear_from_alu -> sleep cleared, pushes resume.
- i_data_stall=1 with i_clear_from_alu=1 -> no flush, no predictor write; drop stall -> flush and counter 0x40 index WT->WNT.
- Confirm twice at PC 0x8 from WT -> ST; subsequent fetch of 0x8 -> o_taken_ff=3 (and =1 with ZAP_FETCH_BP_EN undefined).
